control_unit_seq: RTL

- Sequential control unit that sits directly upstream of the microc datapath.
- Consumes the datapath's Opcode and z.
- Drives s_inc, s_inm, we3, wez and Op, plus a new PC write enable pc_we.
- Adds an init delay, a HALT instruction, a single-step debug mode, an instruction-retire counter and a sticky illegal-opcode flag.
- Decode is combinational and same-cycle (single-cycle datapath); a state machine gates every architectural write.

---
 rtl/control_unit_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/control_unit_seq.sv
// Sequential control unit for the microc datapath. Decode is combinational;
// an INIT/RUN/STEP/HALT machine gates every architectural write.
module control_unit_seq #(
  parameter int INIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run_mode,
  input  logic             step,
  input  logic             resume,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STEP, S_HALT} state_t;

  state_t            state;
  logic [INIT_W-1:0] init_cnt;
  logic              step_q;
  logic              step_rise;
  logic              exec;

  logic raw_s_inc;
  logic raw_we3;
  logic raw_wez;
  logic is_halt;
  logic raw_illegal;

  always_comb begin
    raw_s_inc   = 1'b1;
    s_inm       = 1'b0;
    raw_we3     = 1'b0;
    raw_wez     = 1'b0;
    Op          = 3'b000;
    is_halt     = 1'b0;
    raw_illegal = 1'b0;
    case (Opcode[5:4])
      2'b00: begin
        s_inm   = 1'b1;
        raw_we3 = 1'b1;
      end
      2'b01: begin
        if (!Opcode[3]) begin
          raw_we3 = 1'b1;
          raw_wez = 1'b1;
          Op      = Opcode[2:0];
        end else begin
          raw_illegal = 1'b1;
        end
      end
      2'b10: begin
        case (Opcode[3:0])
          4'h0:    raw_s_inc = 1'b0;
          4'h1:    raw_s_inc = ~z;
          4'h2:    raw_s_inc = z;
          default: raw_illegal = 1'b1;
        endcase
      end
      default: begin
        if (Opcode[3:0] == 4'hF) is_halt = 1'b1;
        else                     raw_illegal = 1'b1;
      end
    endcase
  end

  // Only one instruction executes per step request, however long step is held.
  always_comb begin
    step_rise = step & ~step_q;
    exec      = (state == S_RUN) | ((state == S_STEP) & step_rise);
    we3       = raw_we3 & exec;
    wez       = raw_wez & exec;
    pc_we     = (exec & ~is_halt) | ((state == S_HALT) & resume);
    s_inc     = (state == S_HALT) ? 1'b1 : raw_s_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      step_q   <= 1'b0;
      retired  <= '0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      step_q <= step;
      if (exec) begin
        retired <= retired + CNT_W'(1);
        if (raw_illegal) illegal <= 1'b1;
      end
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) state <= run_mode ? S_RUN : S_STEP;
          else                       init_cnt <= init_cnt + INIT_W'(1);
        end
        S_RUN: begin
          if (is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!run_mode) begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if (step_rise && is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (run_mode) begin
            state <= S_RUN;
          end
        end
        S_HALT: begin
          if (resume) begin
            halted <= 1'b0;
            state  <= run_mode ? S_RUN : S_STEP;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
